// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/hazard controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRefill,
      StDone
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Pipeline-register write enables, PC first.
   typedef struct packed {
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
   } en_vec_t;

   localparam en_vec_t EN_ALL    = '{default: 1'b1};
   localparam en_vec_t EN_NONE   = '{default: 1'b0};
   // Frozen pipeline: only MEM/WB loads, and it loads a bubble.
   localparam en_vec_t EN_FREEZE = '{pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b1};

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between ID/EX load and IF/ID sources.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       idex_mem_read,
   input  logic [4:0] idex_rt,
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   output logic       load_use
);

   always_comb begin
      load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
                 ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall sequencer: load-use bubbles and data-cache miss freeze with block refill.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REFILL_WORDS = 4,
   parameter int unsigned IDX_W        = $clog2(REFILL_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_access,
   input  logic             in_hit,
   input  logic             mem_ready,
   input  logic             idex_MemRead,
   input  logic [4:0]       idex_rt,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   output logic             en_PC,
   output logic             en_IFID,
   output logic             en_IDEX,
   output logic             en_EXMEM,
   output logic             en_MEMWB,
   output logic             flush_IDEX,
   output logic             bubble_MEMWB,
   output logic             mem_req,
   output logic             refill_we,
   output logic [IDX_W-1:0] refill_idx,
   output logic             busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REFILL_WORDS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             load_use;
   en_vec_t          en;

   hazard_detect u_hazard_detect (
      .idex_mem_read (idex_MemRead),
      .idex_rt       (idex_rt),
      .ifid_rs       (ifid_rs),
      .ifid_rt       (ifid_rt),
      .load_use      (load_use)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      en           = EN_ALL;
      flush_IDEX   = 1'b0;
      bubble_MEMWB = 1'b0;
      mem_req      = 1'b0;
      refill_we    = 1'b0;
      refill_idx   = '0;
      busy         = 1'b0;

      case (state_q)
         StIdle: begin
            // A miss outranks load-use; the hazard is seen again once the refill is over.
            if (mem_access && !in_hit) begin
               en           = EN_FREEZE;
               bubble_MEMWB = 1'b1;
               busy         = 1'b1;
               state_d      = StRefill;
            end else if (load_use) begin
               en.pc      = 1'b0;
               en.ifid    = 1'b0;
               flush_IDEX = 1'b1;
            end
         end
         StRefill: begin
            en           = EN_FREEZE;
            bubble_MEMWB = 1'b1;
            busy         = 1'b1;
            mem_req      = 1'b1;
            refill_idx   = cnt_q;
            if (mem_ready) begin
               refill_we = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            en           = EN_FREEZE;
            bubble_MEMWB = 1'b1;
            busy         = 1'b1;
            state_d      = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      if (rst) begin
         en           = EN_NONE;
         flush_IDEX   = 1'b0;
         bubble_MEMWB = 1'b0;
         mem_req      = 1'b0;
         refill_we    = 1'b0;
         refill_idx   = '0;
         busy         = 1'b0;
      end
   end

   assign en_PC    = en.pc;
   assign en_IFID  = en.ifid;
   assign en_IDEX  = en.idex;
   assign en_EXMEM = en.exmem;
   assign en_MEMWB = en.memwb;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed vector table, then random traffic against a reference model.
module tb_pipe_stall_ctrl;

   localparam int unsigned RW = 4;
   localparam int unsigned IW = 2;

   // Output vector: {en PC,IFID,IDEX,EXMEM,MEMWB, flush, bubble, mem_req, refill_we, busy, idx}
   localparam logic [11:0] NORM  = 12'b111110000000;
   localparam logic [11:0] RSTV  = 12'b000000000000;
   localparam logic [11:0] FRZ   = 12'b000010100100;
   localparam logic [11:0] LU    = 12'b001111000000;
   localparam logic [11:0] RWAIT = 12'b000010110100;
   localparam logic [11:0] B0    = 12'b000010111100;
   localparam logic [11:0] B1    = 12'b000010111101;
   localparam logic [11:0] B2    = 12'b000010111110;
   localparam logic [11:0] B3    = 12'b000010111111;

   logic          clk = 1'b0;
   logic          rst, mem_access, in_hit, mem_ready, idex_MemRead;
   logic [4:0]    idex_rt, ifid_rs, ifid_rt;
   logic          en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
   logic          flush_IDEX, bubble_MEMWB, mem_req, refill_we, busy;
   logic [IW-1:0] refill_idx;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(
      .REFILL_WORDS (RW),
      .IDX_W        (IW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_access   (mem_access),
      .in_hit       (in_hit),
      .mem_ready    (mem_ready),
      .idex_MemRead (idex_MemRead),
      .idex_rt      (idex_rt),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .en_PC        (en_PC),
      .en_IFID      (en_IFID),
      .en_IDEX      (en_IDEX),
      .en_EXMEM     (en_EXMEM),
      .en_MEMWB     (en_MEMWB),
      .flush_IDEX   (flush_IDEX),
      .bubble_MEMWB (bubble_MEMWB),
      .mem_req      (mem_req),
      .refill_we    (refill_we),
      .refill_idx   (refill_idx),
      .busy         (busy)
   );

   typedef struct {
      string       name;
      logic        rst, acc, hit, rdy, mr;
      logic [4:0]  irt, rs, rt;
      logic [11:0] exp;
      bit          idx_care;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: remaining refill beats and a pending one-cycle re-read.
   int beats_left = 0;
   bit done_pend  = 1'b0;

   function automatic void add(string name, logic r, logic acc, logic hit, logic rdy, logic mr,
                               logic [4:0] irt, logic [4:0] rs, logic [4:0] rt,
                               logic [11:0] exp, bit idx_care);
      vec_t v;
      v.name = name; v.rst = r; v.acc = acc; v.hit = hit; v.rdy = rdy; v.mr = mr;
      v.irt = irt; v.rs = rs; v.rt = rt; v.exp = exp; v.idx_care = idx_care;
      vecs.push_back(v);
   endfunction

   function automatic logic [11:0] actual();
      return {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB, flush_IDEX, bubble_MEMWB,
              mem_req, refill_we, busy, refill_idx};
   endfunction

   function automatic void model_exp(output logic [11:0] e, output bit idx_care);
      bit lu;
      lu = idex_MemRead && (idex_rt != 5'd0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
      idx_care = 1'b1;
      if (rst) e = RSTV;
      else if (done_pend) e = FRZ;
      else if (beats_left > 0) begin
         e = {5'b00001, 1'b0, 1'b1, 1'b1, mem_ready, 1'b1, IW'(RW - beats_left)};
         idx_care = mem_ready;
      end else if (mem_access && !in_hit) e = FRZ;
      else if (lu) e = LU;
      else e = NORM;
   endfunction

   task automatic check_now(string name, logic [11:0] exp, bit idx_care);
      logic [11:0] a;
      logic [11:0] m;
      a = actual();
      m = idx_care ? 12'hFFF : 12'hFFC;
      checks++;
      if ((a & m) !== (exp & m)) begin
         errors++;
         $display("FAIL %s at %0t: got %b want %b (mask %b)", name, $time, a, exp, m);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         beats_left = 0;
         done_pend  = 1'b0;
      end else if (done_pend) begin
         done_pend = 1'b0;
      end else if (beats_left > 0) begin
         if (mem_ready) begin
            beats_left--;
            if (beats_left == 0) done_pend = 1'b1;
         end
      end else if (mem_access && !in_hit) begin
         beats_left = RW;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [11:0] e;
      bit          ic;

      rst = 1'b1; mem_access = 1'b0; in_hit = 1'b1; mem_ready = 1'b0;
      idex_MemRead = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;

      //   name          rst acc hit rdy mr  irt    rs     rt     exp    idx
      add("rst0",        1,  1,  1,  0,  0,  5'd0,  5'd0,  5'd0,  RSTV,  1);
      add("rst1",        1,  1,  1,  0,  0,  5'd0,  5'd0,  5'd0,  RSTV,  1);
      add("hit0",        0,  1,  1,  0,  0,  5'd0,  5'd0,  5'd0,  NORM,  1);
      add("hit1",        0,  1,  1,  1,  0,  5'd0,  5'd0,  5'd0,  NORM,  1);
      add("miss_det",    0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  FRZ,   1);
      add("beat0",       0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B0,    1);
      add("beat1",       0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B1,    1);
      add("beat2",       0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B2,    1);
      add("beat3",       0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B3,    1);
      add("done",        0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  FRZ,   1);
      add("after_miss",  0,  1,  1,  1,  0,  5'd0,  5'd0,  5'd0,  NORM,  1);
      add("miss2_det",   0,  1,  0,  0,  0,  5'd0,  5'd0,  5'd0,  FRZ,   1);
      add("m2_r1",       0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B0,    1);
      add("m2_r0a",      0,  1,  0,  0,  0,  5'd0,  5'd0,  5'd0,  RWAIT, 0);
      add("m2_r0b",      0,  1,  0,  0,  0,  5'd0,  5'd0,  5'd0,  RWAIT, 0);
      add("m2_r1b",      0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B1,    1);
      add("m2_r1c",      0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B2,    1);
      add("m2_r0c",      0,  1,  0,  0,  0,  5'd0,  5'd0,  5'd0,  RWAIT, 0);
      add("m2_r1d",      0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B3,    1);
      add("m2_done",     0,  1,  0,  0,  0,  5'd0,  5'd0,  5'd0,  FRZ,   1);
      add("m2_after",    0,  1,  1,  0,  0,  5'd0,  5'd0,  5'd0,  NORM,  1);
      add("lu_rs",       0,  0,  1,  0,  1,  5'd8,  5'd8,  5'd2,  LU,    1);
      add("lu_bubble",   0,  0,  1,  0,  0,  5'd8,  5'd8,  5'd2,  NORM,  1);
      add("lu_zero",     0,  0,  1,  0,  1,  5'd0,  5'd0,  5'd0,  NORM,  1);
      add("lu_rt",       0,  0,  1,  0,  1,  5'd8,  5'd3,  5'd8,  LU,    1);
      add("both_det",    0,  1,  0,  1,  1,  5'd9,  5'd9,  5'd1,  FRZ,   1);
      add("both_b0",     0,  1,  0,  1,  1,  5'd9,  5'd9,  5'd1,  B0,    1);
      add("both_b1",     0,  1,  0,  1,  1,  5'd9,  5'd9,  5'd1,  B1,    1);
      add("both_b2",     0,  1,  0,  1,  1,  5'd9,  5'd9,  5'd1,  B2,    1);
      add("both_b3",     0,  1,  0,  1,  1,  5'd9,  5'd9,  5'd1,  B3,    1);
      add("both_done",   0,  1,  0,  1,  1,  5'd9,  5'd9,  5'd1,  FRZ,   1);
      add("both_lu",     0,  1,  1,  1,  1,  5'd9,  5'd9,  5'd1,  LU,    1);
      add("both_clear",  0,  1,  1,  1,  0,  5'd9,  5'd9,  5'd1,  NORM,  1);
      add("rm_det",      0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  FRZ,   1);
      add("rm_b0",       0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B0,    1);
      add("rm_rst",      1,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  RSTV,  1);
      add("rm_idle",     0,  0,  1,  1,  0,  5'd0,  5'd0,  5'd0,  NORM,  1);
      add("rm2_det",     0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  FRZ,   1);
      add("rm2_b0",      0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B0,    1);
      add("rm2_b1",      0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B1,    1);
      add("rm2_b2",      0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B2,    1);
      add("rm2_b3",      0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  B3,    1);
      add("rm2_done",    0,  1,  0,  1,  0,  5'd0,  5'd0,  5'd0,  FRZ,   1);
      add("rm2_after",   0,  1,  1,  1,  0,  5'd0,  5'd0,  5'd0,  NORM,  1);

      @(negedge clk);
      foreach (vecs[i]) begin
         rst = vecs[i].rst; mem_access = vecs[i].acc; in_hit = vecs[i].hit;
         mem_ready = vecs[i].rdy; idex_MemRead = vecs[i].mr; idex_rt = vecs[i].irt;
         ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt;
         #2;
         check_now(vecs[i].name, vecs[i].exp, vecs[i].idx_care);
         tick();
      end

      // Random traffic against the reference model, small register range for collisions.
      for (int n = 0; n < 600; n++) begin
         rst          = (n == 0) || ($urandom_range(39) == 0);
         mem_access   = $urandom_range(1);
         in_hit       = ($urandom_range(9) < 7);
         mem_ready    = ($urandom_range(9) < 6);
         idex_MemRead = $urandom_range(1);
         idex_rt      = 5'($urandom_range(3));
         ifid_rs      = 5'($urandom_range(3));
         ifid_rt      = 5'($urandom_range(3));
         #2;
         model_exp(e, ic);
         check_now("rand", e, ic);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
